// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and a one-hot opcode decoder.
// Imported by the ALU, the instruction decoder and the control unit.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_sll;
        logic is_slt;
        logic is_sltu;
        logic is_xor;
        logic is_srl;
        logic is_sra;
        logic is_or;
        logic is_and;
    } op_dec_t;

    // All flags clear means the code is undefined.
    function automatic op_dec_t decode_op(input logic [3:0] op);
        op_dec_t d;
        d         = '0;
        d.is_add  = (op == ALU_ADD);
        d.is_sub  = (op == ALU_SUB);
        d.is_sll  = (op == ALU_SLL);
        d.is_slt  = (op == ALU_SLT);
        d.is_sltu = (op == ALU_SLTU);
        d.is_xor  = (op == ALU_XOR);
        d.is_srl  = (op == ALU_SRL);
        d.is_sra  = (op == ALU_SRA);
        d.is_or   = (op == ALU_OR);
        d.is_and  = (op == ALU_AND);
        return d;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter: SLL, SRL and SRA.
// Left shifts reuse the right-shift stages on a bit-reversed operand.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               right_i,
    input  logic               arith_i,
    output logic [WIDTH-1:0]   res_o
);

    logic [WIDTH-1:0]              rev_in;
    logic [WIDTH-1:0]              rev_out;
    logic [SHAMT_W:0][WIDTH-1:0]   stage;
    logic                          fill;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev_in[i]  = a_i[WIDTH-1-i];
        assign rev_out[i] = stage[SHAMT_W][WIDTH-1-i];
    end

    // Sign fill only for arithmetic right shifts.
    assign fill     = right_i & arith_i & a_i[WIDTH-1];
    assign stage[0] = right_i ? a_i : rev_in;

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int SH = 1 << s;
        assign stage[s+1] = shamt_i[s]
                          ? {{SH{fill}}, stage[s][WIDTH-1:SH]}
                          : stage[s];
    end

    assign res_o = right_i ? stage[SHAMT_W] : rev_out;

endmodule

// File: rtl/alu.sv
// RV32I execute-stage integer ALU.
// Combinational result and flags, plus a registered result copy.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] out_q,
    output logic             illegal_op
);

    op_dec_t          dec;
    logic             use_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             lt_u;
    logic             lt_s;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;

    assign dec = decode_op(op);

    // One adder serves ADD, SUB and both compares (a + ~b + 1).
    assign use_sub = dec.is_sub | dec.is_slt | dec.is_sltu;
    assign b_eff   = use_sub ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, b_eff}
                   + {{WIDTH{1'b0}}, use_sub};

    assign lt_u = ~sum[WIDTH];
    assign lt_s = (a[WIDTH-1] != b[WIDTH-1])
                ? a[WIDTH-1]
                : sum[WIDTH-1];

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a_i     (a),
        .shamt_i (b[SHAMT_W-1:0]),
        .right_i (op[2]),
        .arith_i (op[3]),
        .res_o   (shift_res)
    );

    always_comb begin
        res = '0;
        unique case (1'b1)
            dec.is_add,
            dec.is_sub:  res = sum[WIDTH-1:0];
            dec.is_sll,
            dec.is_srl,
            dec.is_sra:  res = shift_res;
            dec.is_slt:  res = {{(WIDTH-1){1'b0}}, lt_s};
            dec.is_sltu: res = {{(WIDTH-1){1'b0}}, lt_u};
            dec.is_xor:  res = a ^ b;
            dec.is_or:   res = a | b;
            dec.is_and:  res = a & b;
            default:     res = '0;
        endcase
    end

    assign out        = res;
    assign zero       = (res == '0);
    assign illegal_op = ~(|dec);

    assign res_d = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign out_q = res_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the ALU: random and directed vectors
// checked against a behavioural model, plus out_q/reset checks.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] out;
    logic        zero;
    logic [31:0] out_q;
    logic        illegal_op;

    alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .op         (op),
        .out        (out),
        .zero       (zero),
        .out_q      (out_q),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_reg;
        logic [31:0] eo;
        bit          ei;
        string       nm;
    } exp_t;

    exp_t        sbq[$];
    event        sample_ev;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] prev_out;

    function automatic logic [31:0] ref_alu(input logic [3:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        int unsigned sh;
        int          sx;
        int          sy;
        sh = y % 32;
        sx = x;
        sy = y;
        case (o)
            4'b0000: return x + y;
            4'b1000: return x - y;
            4'b0001: return x << sh;
            4'b0010: return (sx < sy) ? 32'd1 : 32'd0;
            4'b0011: return (x < y) ? 32'd1 : 32'd0;
            4'b0100: return x ^ y;
            4'b0101: return x >> sh;
            4'b1101: return 32'(sx >>> sh);
            4'b0110: return x | y;
            4'b0111: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_ill(input logic [3:0] o);
        return !(o inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                           4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111});
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 64));
            default: return $urandom;
        endcase
    endfunction

    task automatic post(input bit r, input logic [31:0] eo,
                        input bit ei, input string nm);
        exp_t e;
        e.is_reg = r;
        e.eo     = eo;
        e.ei     = ei;
        e.nm     = nm;
        sbq.push_back(e);
        -> sample_ev;
    endtask

    // Apply just after a rising edge, check out 1 unit later (no edge in
    // between), and check out_q of the previous vector first.
    task automatic drive(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eo,
                         input bit ei, input string nm);
        @(posedge clk);
        #1;
        post(1'b1, prev_out, 1'b0, {nm, " out_q"});
        op = o;
        a  = x;
        b  = y;
        #1;
        post(1'b0, eo, ei, nm);
        prev_out = eo;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                vectors++;
                if (e.is_reg) begin
                    if (out_q !== e.eo) begin
                        miscompares++;
                        $display("FAIL %s: out_q=%08h expected %08h",
                                 e.nm, out_q, e.eo);
                    end
                end else if (out !== e.eo || zero !== (e.eo == 32'd0)
                             || illegal_op !== e.ei) begin
                    miscompares++;
                    $display("FAIL %s: op=%b a=%08h b=%08h out=%08h zero=%b ill=%b expected out=%08h zero=%b ill=%b",
                             e.nm, op, a, b, out, zero, illegal_op,
                             e.eo, (e.eo == 32'd0), e.ei);
                end
            end
        end
    end

    logic [3:0] legal_ops[10];
    logic [3:0] bad_ops[6];

    initial begin : stim
        logic [31:0] x;
        logic [31:0] y;
        legal_ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
        bad_ops   = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        op       = ALU_ADD;
        prev_out = '0;

        #3 post(1'b1, 32'd0, 1'b0, "reset out_q");
        @(posedge clk);
        #1 post(1'b1, 32'd0, 1'b0, "reset hold");
        @(negedge clk);
        rst_n = 1'b1;

        drive(ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, "add wrap");
        drive(ALU_ADD,  32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, "add");
        drive(ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, "sub");
        drive(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, "slt");
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, "sltu");
        drive(ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0, "sra");
        drive(ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 0, "srl");
        drive(ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 0, "sll 33");
        drive(ALU_SRA,  32'h9234_5678, 32'h0000_0020, 32'h9234_5678, 0, "sra by 0");
        drive(ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, "and");
        drive(ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, "or");
        drive(ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, "xor");
        drive(4'b1111,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 1, "illegal");

        for (int i = 0; i < 10; i++) begin
            for (int n = 0; n < 1000; n++) begin
                x = rnd_operand();
                y = rnd_operand();
                drive(legal_ops[i], x, y, ref_alu(legal_ops[i], x, y),
                      ref_ill(legal_ops[i]),
                      $sformatf("rand op=%b", legal_ops[i]));
            end
        end
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < 20; n++) begin
                x = $urandom;
                y = $urandom;
                drive(bad_ops[i], x, y, 32'd0, ref_ill(bad_ops[i]),
                      $sformatf("rand bad op=%b", bad_ops[i]));
            end
        end

        drive(ALU_OR, 32'hDEAD_0000, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, "pre-reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1 post(1'b1, 32'd0, 1'b0, "async reset");
        op = ALU_ADD;
        a  = 32'd3;
        b  = 32'd4;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 post(1'b1, 32'd7, 1'b0, "reset release");
        prev_out = 32'd7;
        drive(ALU_SUB, 32'd10, 32'd10, 32'd0, 0, "sub zero");
        drive(ALU_ADD, 32'd1, 32'd1, 32'd2, 0, "final");

        @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Integer ALU for the RV32I core execute stage.
- Computes all RV32I register/immediate arithmetic, logic, compare and shift results from two operands and a 4-bit operation code.
- The primary result is purely combinational, so it is valid in the same cycle as its operands.
- Also provides a zero flag for branch logic and a registered copy of the result for pipelined consumers.

Parameters:
- WIDTH, 32, operand/result width in bits; the core uses 32 only.
- SHAMT_W, $clog2(WIDTH) = 5, number of low-order b bits used as the shift amount.

Ports:
- clk  input  1  core clock; clocks only the registered outputs.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A (rs1 or PC).
- b  input  WIDTH  operand B (rs2 or immediate); b[SHAMT_W-1:0] is the shift amount.
- op  input  4  operation select, encoded as {funct7[5], funct3}.
- out  output  WIDTH  combinational result.
- zero  output  1  combinational; high when out == 0.
- out_q  output  WIDTH  out registered on the rising edge of clk.
- illegal_op  output  1  combinational; high when op is not one of the defined codes.

Behaviour:
- out is a pure function of a, b and op. There is no clock dependency and zero latency. out must settle within one propagation delay of any input change, with no clock edge required.
- Op encoding and result:
  - 0000 ADD: a + b, modulo 2^WIDTH; carry discarded.
  - 1000 SUB: a - b, modulo 2^WIDTH; borrow discarded.
  - 0001 SLL: a << b[4:0]; zero fill.
  - 0010 SLT: 1 if $signed(a) < $signed(b), else 0; zero-extended to WIDTH.
  - 0011 SLTU: 1 if a < b unsigned, else 0; zero-extended.
  - 0100 XOR: a ^ b.
  - 0101 SRL: a >> b[4:0]; zero fill.
  - 1101 SRA: $signed(a) >>> b[4:0]; fills with a[WIDTH-1].
  - 0110 OR: a | b.
  - 0111 AND: a & b.
- Undefined codes (1001, 1010, 1011, 1100, 1110, 1111): out = 0, illegal_op = 1, zero = 1.
- Shift rules:
  - Only b[4:0] is used; b[31:5] is ignored (shift by 33 behaves as shift by 1).
  - Shift by 0 returns a unchanged.
- SLT/SLTU compare the full WIDTH bits of b.
- SUB and SLT share one adder computing a + ~b + 1.
  - SLTU = NOT carry-out.
  - SLT = sign(a) != sign(b) ? a[31] : diff[31].
- No internal state feeds out; clk and rst_n affect only out_q.
- out_q:
  - Resets asynchronously to 0 while rst_n is low.
  - Otherwise captures out on each rising clk edge.
  - Releasing reset mid-stream resumes capture at the next rising edge.
- Outputs must be free of X whenever a, b and op are known.

Decomposition:
- Package alu_pkg holds:
  - the localparams ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, with the values above;
  - XLEN = 32.
  - The decoder and control unit import the same constants.
- One sub-module, alu_shifter, is natural: a 5-stage logarithmic barrel shifter handling left, logical right and arithmetic right, selected by op[3] and op[2].
- The adder/comparator and logic ops stay in alu.

Test Plan:
- ADD: a=0xFFFFFFFF, b=0x00000001, op=0000 -> out=0x00000000, zero=1. Then a=0x12345678, b=0x11111111 -> out=0x23456789.
- SUB/compare: a=0, b=1, op=1000 -> out=0xFFFFFFFF. With a=0xFFFFFFFF, b=1: op=0010 -> out=1; op=0011 -> out=0.
- Shifts:
  - a=0x80000000, b=0x00000004: op=1101 -> 0xF8000000; op=0101 -> 0x08000000.
  - a=1, b=0x00000021, op=0001 -> 0x00000002 (upper shift bits ignored).
- Logic: a=0xF0F0F0F0, b=0xFF00FF00: op=0111 -> 0xF000F000; op=0110 -> 0xFFF0FFF0; op=0100 -> 0x0FF00FF0. Also op=1111 -> out=0, illegal_op=1.
- Randomized: 1000 random a/b per defined op, checked against the reference expressions one propagation delay after the inputs are applied, with no clock edge between stimulus and check.
- Register: assert rst_n=0 -> out_q=0 immediately, without waiting for clk. Release reset with ADD 3+4 applied -> out_q=7 after the next rising edge.
